// File: rtl/posit_div_core_if.sv
// Operand and result bundle for posit_div_core: two decoded posit32 inputs in, decoded quotient fields out.
// The master side drives start and the operands; the slave side is the divide core.
interface posit_div_core_if #(
   parameter int ES     = 3,
   parameter int K_BITS = 6,
   parameter int MW     = 32
);
   logic              start;
   logic              sign_a;
   logic              zero_a;
   logic              nar_a;
   logic [K_BITS-1:0] k_a;
   logic [ES-1:0]     exp_a;
   logic [MW-1:0]     mant_a;
   logic              sign_b;
   logic              zero_b;
   logic              nar_b;
   logic [K_BITS-1:0] k_b;
   logic [ES-1:0]     exp_b;
   logic [MW-1:0]     mant_b;
   logic              busy;
   logic              done;
   logic              sign_out;
   logic [K_BITS-1:0] k_out;
   logic [ES-1:0]     exp_out;
   logic [MW-1:0]     mant_out;
   logic              sticky;
   logic              nar_out;
   logic              zero_out;
   logic              sat_out;

   modport master (
      output start, sign_a, zero_a, nar_a, k_a, exp_a, mant_a,
             sign_b, zero_b, nar_b, k_b, exp_b, mant_b,
      input  busy, done, sign_out, k_out, exp_out, mant_out,
             sticky, nar_out, zero_out, sat_out
   );

   modport slave (
      input  start, sign_a, zero_a, nar_a, k_a, exp_a, mant_a,
             sign_b, zero_b, nar_b, k_b, exp_b, mant_b,
      output busy, done, sign_out, k_out, exp_out, mant_out,
             sticky, nar_out, zero_out, sat_out
   );
endinterface

// File: rtl/posit_div_core.sv
// Sequential posit32 (ES=3) divide core: scale subtractor plus restoring divider over decoded fields.
// Define POSIT_DIV_EARLY_TERM_EN to leave the divide loop as soon as the partial remainder reaches zero.
module posit_div_core #(
   parameter int ES     = 3,
   parameter int K_BITS = 6,
   parameter int MW     = 32,
   parameter int QW     = 34
) (
   input  logic           clk,
   input  logic           rst_n,
   posit_div_core_if.slave dif
);
   localparam int SW    = K_BITS + ES + 1;
   localparam int CW    = $clog2(QW);
   localparam int S_MAX = ((1 << (K_BITS - 1)) - 2) << ES;
   localparam int S_MIN = -(((1 << (K_BITS - 1)) - 1) << ES);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

   state_t               state_q;
   logic [MW:0]          rem_q;
   logic [MW-1:0]        div_q;
   logic [QW-1:0]        quo_q;
   logic signed [SW-1:0] scale_q;
   logic [CW-1:0]        cnt_q;
   logic                 sign_q;

   logic              busy_q, done_q, sign_out_q, sticky_q, nar_q, zero_q, sat_q;
   logic [K_BITS-1:0] k_q;
   logic [ES-1:0]     exp_q;
   logic [MW-1:0]     mant_q;

   logic signed [SW-1:0] scale_d;
   logic                 rem_ge;
   logic [MW:0]          rem_sub;
   logic [MW:0]          rem_d;
   logic [QW-1:0]        quo_d;
   logic [QW-1:0]        quo_n;
   logic signed [SW-1:0] scale_n;
   logic signed [SW-1:0] scale_f;
   logic                 sticky_n, ovf_n, unf_n;
   logic                 nar_in, zero_in;

   // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
   always_comb begin
      // {k, exp} with one extra sign bit is exactly k*2^ES + exp in two's complement.
      scale_d = signed'({dif.k_a[K_BITS-1], dif.k_a, dif.exp_a})
              - signed'({dif.k_b[K_BITS-1], dif.k_b, dif.exp_b});
      nar_in  = dif.nar_a | dif.nar_b | dif.zero_b;
      zero_in = dif.zero_a;

      rem_ge  = rem_q >= {1'b0, div_q};
      rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
      rem_d   = rem_sub << 1;
      quo_d   = {quo_q[QW-2:0], rem_ge};

      quo_n    = quo_q[QW-1] ? quo_q : (quo_q << 1);
      scale_n  = quo_q[QW-1] ? scale_q : (scale_q - SW'(1));
      sticky_n = (|quo_n[QW-MW-1:0]) | (|rem_q);
      ovf_n    = int'(scale_n) > S_MAX;
      unf_n    = int'(scale_n) < S_MIN;
      scale_f  = ovf_n ? SW'(S_MAX) : (unf_n ? SW'(S_MIN) : scale_n);
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rem_q      <= '0;
         div_q      <= '0;
         quo_q      <= '0;
         scale_q    <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sign_out_q <= 1'b0;
         k_q        <= '0;
         exp_q      <= '0;
         mant_q     <= '0;
         sticky_q   <= 1'b0;
         nar_q      <= 1'b0;
         zero_q     <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (dif.start) begin
                  if (nar_in || zero_in) begin
                     sign_out_q <= 1'b0;
                     k_q        <= '0;
                     exp_q      <= '0;
                     mant_q     <= '0;
                     sticky_q   <= 1'b0;
                     sat_q      <= 1'b0;
                     nar_q      <= nar_in;
                     zero_q     <= ~nar_in;
                     done_q     <= 1'b1;
                     state_q    <= S_DONE;
                  end else begin
                     rem_q   <= {1'b0, dif.mant_a};
                     div_q   <= dif.mant_b;
                     quo_q   <= '0;
                     cnt_q   <= '0;
                     scale_q <= scale_d;
                     sign_q  <= dif.sign_a ^ dif.sign_b;
                     busy_q  <= 1'b1;
                     state_q <= S_DIV;
                  end
               end
            end
            S_DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(QW - 1)) begin
                  state_q <= S_NORM;
               end
`ifdef POSIT_DIV_EARLY_TERM_EN
               // Exact quotient: left-align the bits produced so far, the rest are zero.
               if (rem_sub == '0) begin
                  quo_q   <= quo_d << (CW'(QW - 1) - cnt_q);
                  state_q <= S_NORM;
               end
`endif
            end
            S_NORM: begin
               sign_out_q <= sign_q;
               k_q        <= scale_f[ES+K_BITS-1:ES];
               exp_q      <= scale_f[ES-1:0];
               mant_q     <= (ovf_n || unf_n) ? {1'b1, {(MW-1){1'b0}}} : quo_n[QW-1 -: MW];
               sticky_q   <= sticky_n;
               sat_q      <= ovf_n | unf_n;
               nar_q      <= 1'b0;
               zero_q     <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               state_q    <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign dif.busy     = busy_q;
   assign dif.done     = done_q;
   assign dif.sign_out = sign_out_q;
   assign dif.k_out    = k_q;
   assign dif.exp_out  = exp_q;
   assign dif.mant_out = mant_q;
   assign dif.sticky   = sticky_q;
   assign dif.nar_out  = nar_q;
   assign dif.zero_out = zero_q;
   assign dif.sat_out  = sat_q;
endmodule
